// File: rtl/mult_result_reader.sv
// Reads result lines through an Avalon-MM slave (line-select write, then WORDS pipelined slice reads)
// and presents each assembled line on a valid/ready stream; slave stalls and stream backpressure hold state.
module mult_result_reader #(
   parameter int LINE_AW       = 8,
   parameter int WORDS         = 8,
   parameter int LINE_SEL_ADDR = 16,
   parameter int READ_LATENCY  = 1
) (
   input  logic                  avalon_clock,
   input  logic                  reset,
   input  logic                  start,
   input  logic [LINE_AW-1:0]    first_line,
   input  logic [LINE_AW:0]      num_lines,
   output logic                  busy,
   output logic                  done,
   output logic                  m_read,
   output logic                  m_write,
   output logic [4:0]            m_address,
   output logic [31:0]           m_writedata,
   input  logic [31:0]           m_readdata,
   input  logic                  m_waitrequest,
   output logic                  line_valid,
   input  logic                  line_ready,
   output logic [32*WORDS-1:0]   line_data,
   output logic [LINE_AW-1:0]    line_index
);

   localparam int SW = (WORDS > 1) ? $clog2(WORDS) : 1;
   localparam int CW = $clog2(WORDS + 1);

   typedef enum logic [2:0] {IDLE, SEL, RD, DRAIN, OUT, FIN} state_t;

   state_t                             state_q, state_d;
   logic [LINE_AW-1:0]                 line_q, line_d;
   logic [LINE_AW:0]                   remain_q, remain_d;
   logic [SW-1:0]                      slice_q, slice_d;
   logic [CW-1:0]                      cap_cnt_q;
   logic [READ_LATENCY-1:0]            pend_vld_q;
   logic [READ_LATENCY-1:0][SW-1:0]    pend_idx_q;
   logic [32*WORDS-1:0]                line_data_q;
   logic                               rd_accept;

   assign rd_accept  = (state_q == RD) && !m_waitrequest;
   assign line_data  = line_data_q;
   assign line_index = line_q;

   always_ff @(posedge avalon_clock) begin
      if (reset) begin
         state_q  <= IDLE;
         line_q   <= '0;
         remain_q <= '0;
         slice_q  <= '0;
      end else begin
         state_q  <= state_d;
         line_q   <= line_d;
         remain_q <= remain_d;
         slice_q  <= slice_d;
      end
   end

   // Each accepted read carries its slice number down a READ_LATENCY-deep pipe; reset flushes it
   // so data still in flight at the slave is never captured.
   always_ff @(posedge avalon_clock) begin
      if (reset) begin
         pend_vld_q  <= '0;
         pend_idx_q  <= '0;
         cap_cnt_q   <= '0;
         line_data_q <= '0;
      end else begin
         pend_vld_q[0] <= rd_accept;
         pend_idx_q[0] <= slice_q;
         for (int i = 1; i < READ_LATENCY; i++) begin
            pend_vld_q[i] <= pend_vld_q[i-1];
            pend_idx_q[i] <= pend_idx_q[i-1];
         end
         if (state_q == SEL) begin
            cap_cnt_q <= '0;
         end else if (pend_vld_q[READ_LATENCY-1]) begin
            cap_cnt_q <= cap_cnt_q + CW'(1);
            line_data_q[32*pend_idx_q[READ_LATENCY-1] +: 32] <= m_readdata;
         end
      end
   end

   always_comb begin
      state_d     = state_q;
      line_d      = line_q;
      remain_d    = remain_q;
      slice_d     = slice_q;
      busy        = (state_q != IDLE);
      done        = 1'b0;
      m_read      = 1'b0;
      m_write     = 1'b0;
      m_address   = '0;
      m_writedata = '0;
      line_valid  = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) begin
               if (num_lines == '0) begin
                  state_d = FIN;
               end else begin
                  line_d   = first_line;
                  remain_d = num_lines;
                  state_d  = SEL;
               end
            end
         end
         SEL: begin
            m_write     = 1'b1;
            m_address   = 5'(LINE_SEL_ADDR);
            m_writedata = 32'(line_q);
            slice_d     = '0;
            if (!m_waitrequest) state_d = RD;
         end
         RD: begin
            m_read    = 1'b1;
            m_address = 5'(slice_q);
            if (!m_waitrequest) begin
               if (slice_q == SW'(WORDS - 1)) state_d = DRAIN;
               else                           slice_d = slice_q + SW'(1);
            end
         end
         DRAIN: begin
            if (cap_cnt_q == CW'(WORDS)) state_d = OUT;
         end
         OUT: begin
            line_valid = 1'b1;
            if (line_ready) begin
               remain_d = remain_q - (LINE_AW+1)'(1);
               if (remain_q == (LINE_AW+1)'(1)) begin
                  state_d = FIN;
               end else begin
                  line_d  = line_q + LINE_AW'(1);
                  state_d = SEL;
               end
            end
         end
         FIN: begin
            done    = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

endmodule

// File: tb/tb_mult_result_reader.sv
// Drives two readers (read latency 1 and 3) against slave models and a line-level reference queue.
module tb_mult_result_reader;

   localparam int WORDS = 8;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic                    reset;
   logic [1:0]              start;
   logic [7:0]              first_line;
   logic [8:0]              num_lines;
   logic [1:0]              wreq;
   logic [1:0]              ready;
   logic [1:0]              busy, done, m_read, m_write, line_valid;
   logic [1:0][4:0]         m_address;
   logic [1:0][31:0]        m_writedata, m_readdata;
   logic [1:0][255:0]       line_data;
   logic [1:0][7:0]         line_index;
   logic [7:0]              salt;

   function automatic logic [31:0] slv_data(input logic [7:0] ln, input logic [4:0] k);
      return {ln, salt, 11'd0, k};
   endfunction

   for (genvar g = 0; g < 2; g++) begin : g_dut
      localparam int RL = (g == 0) ? 1 : 3;
      logic [31:0] pipe [RL];
      logic [7:0]  sel_line;

      mult_result_reader #(
         .LINE_AW(8), .WORDS(WORDS), .LINE_SEL_ADDR(16), .READ_LATENCY(RL)
      ) u_dut (
         .avalon_clock (clk),
         .reset        (reset),
         .start        (start[g]),
         .first_line   (first_line),
         .num_lines    (num_lines),
         .busy         (busy[g]),
         .done         (done[g]),
         .m_read       (m_read[g]),
         .m_write      (m_write[g]),
         .m_address    (m_address[g]),
         .m_writedata  (m_writedata[g]),
         .m_readdata   (m_readdata[g]),
         .m_waitrequest(wreq[g]),
         .line_valid   (line_valid[g]),
         .line_ready   (ready[g]),
         .line_data    (line_data[g]),
         .line_index   (line_index[g])
      );

      always @(posedge clk) begin
         if (m_write[g] && !wreq[g] && m_address[g] == 5'd16) sel_line <= m_writedata[g][7:0];
         pipe[0] <= (m_read[g] && !wreq[g]) ? slv_data(sel_line, m_address[g]) : 32'hDEAD_BEEF;
         for (int i = 1; i < RL; i++) pipe[i] <= pipe[i-1];
      end
      assign m_readdata[g] = pipe[RL-1];
   end

   typedef struct {
      logic [7:0]   idx;
      logic [255:0] dat;
   } line_t;

   typedef struct {
      int         d;
      logic [7:0] first;
      logic [8:0] num;
      int         stall;
      int         rdy;
      logic [7:0] sl;
      int         exp_lines;
      logic [7:0] exp_last;
   } vec_t;

   line_t        expq [2][$];
   vec_t         tbl [9];
   int           n_vec = 0;
   int           n_bad = 0;
   int           stall_mode [2], rdy_mode [2], wcnt [2], rcnt [2], hcnt [2];
   int           exp_slice [2], dlv [2], done_cnt [2];
   logic [7:0]   last_idx [2];
   logic         p_hold [2], p_cstall [2], p_rd [2], p_wr [2];
   logic [255:0] p_data [2];
   logic [7:0]   p_idx [2];
   logic [4:0]   p_addr [2];
   logic [31:0]  p_wd [2];

   task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic flag(input string nm, input logic [255:0] act);
      n_vec++;
      n_bad++;
      $display("FAIL %s: got %0h where nothing was expected", nm, act);
   endtask

   function automatic line_t mk_line(input logic [7:0] ln);
      line_t r;
      r.idx = ln;
      r.dat = '0;
      for (int k = 0; k < WORDS; k++) r.dat[32*k +: 32] = slv_data(ln, 5'(k));
      return r;
   endfunction

   task automatic clear_prev();
      for (int d = 0; d < 2; d++) begin
         p_hold[d]   = 1'b0;
         p_cstall[d] = 1'b0;
      end
   endtask

   // One clock: choose slave stall / sink ready for this cycle, then check everything visible.
   task automatic tick();
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
         case (stall_mode[d])
            1: wreq[d] = ($urandom_range(0, 2) == 0);
            2: begin
               wreq[d] = 1'b0;
               if (m_write[d]) begin
                  if (wcnt[d] < 3) begin wreq[d] = 1'b1; wcnt[d]++; end
                  else begin wcnt[d] = 0; rcnt[d] = 0; end
               end else if (m_read[d] && m_address[d] == 5'd4 && rcnt[d] < 3) begin
                  wreq[d] = 1'b1;
                  rcnt[d]++;
               end
            end
            default: wreq[d] = 1'b0;
         endcase
         case (rdy_mode[d])
            1: ready[d] = ($urandom_range(0, 1) == 1);
            2: begin
               if (line_valid[d] && hcnt[d] < 5) begin ready[d] = 1'b0; hcnt[d]++; end
               else ready[d] = 1'b1;
            end
            default: ready[d] = 1'b1;
         endcase

         chk("rd_wr_excl", m_read[d] & m_write[d], 0);
         if (line_valid[d]) chk("quiet_in_out", m_read[d] | m_write[d], 0);
         if (p_hold[d]) begin
            chk("hold_valid", line_valid[d], 1);
            chk("hold_data", line_data[d], p_data[d]);
            chk("hold_index", line_index[d], p_idx[d]);
         end
         if (p_cstall[d])
            chk("stall_cmd", {m_read[d], m_write[d], m_address[d], m_writedata[d]},
                {p_rd[d], p_wr[d], p_addr[d], p_wd[d]});
         if (m_write[d] && !wreq[d]) begin
            chk("wr_addr", m_address[d], 16);
            if (expq[d].size() == 0) flag("unexpected_write", m_writedata[d]);
            else chk("wr_line", m_writedata[d], {24'd0, expq[d][0].idx});
            exp_slice[d] = 0;
         end
         if (m_read[d] && !wreq[d]) begin
            chk("rd_slice", m_address[d], exp_slice[d]);
            exp_slice[d]++;
         end
         if (line_valid[d] && ready[d]) begin
            if (expq[d].size() == 0) begin
               flag("unexpected_line", line_index[d]);
            end else begin
               line_t e;
               e = expq[d].pop_front();
               chk("line_index", line_index[d], e.idx);
               chk("line_data", line_data[d], e.dat);
            end
            dlv[d]++;
            last_idx[d] = line_index[d];
         end
         if (done[d]) done_cnt[d]++;

         p_hold[d]   = line_valid[d] && !ready[d] && !reset;
         p_cstall[d] = (m_read[d] | m_write[d]) && wreq[d] && !reset;
         p_data[d]   = line_data[d];
         p_idx[d]    = line_index[d];
         p_rd[d]     = m_read[d];
         p_wr[d]     = m_write[d];
         p_addr[d]   = m_address[d];
         p_wd[d]     = m_writedata[d];
      end
   endtask

   task automatic prep(input int d, input int st, input int rd);
      stall_mode[d] = st;
      rdy_mode[d]   = rd;
      wcnt[d] = 0; rcnt[d] = 0; hcnt[d] = 0; dlv[d] = 0;
   endtask

   task automatic start_readout(input int d, input logic [7:0] first, input logic [8:0] num);
      for (int i = 0; i < int'(num); i++) expq[d].push_back(mk_line(first + 8'(i)));
      first_line = first;
      num_lines  = num;
      start[d]   = 1'b1;
      tick();
      start[d]   = 1'b0;
   endtask

   task automatic wait_done(input int d, input int base, input int budget);
      int n = 0;
      while (done_cnt[d] == base && n < budget) begin tick(); n++; end
      if (done_cnt[d] == base) flag("done_timeout", n);
   endtask

   task automatic check_zero(input int d, input string tag);
      chk({tag, "_busy"}, busy[d], 0);
      chk({tag, "_done"}, done[d], 0);
      chk({tag, "_cmd"}, {m_read[d], m_write[d], line_valid[d]}, 0);
      chk({tag, "_addr"}, m_address[d], 0);
      chk({tag, "_wdata"}, m_writedata[d], 0);
      chk({tag, "_ldata"}, line_data[d], 0);
      chk({tag, "_lindex"}, line_index[d], 0);
   endtask

   task automatic run_vec(input vec_t v);
      int base;
      prep(v.d, v.stall, v.rdy);
      salt = v.sl;
      base = done_cnt[v.d];
      start_readout(v.d, v.first, v.num);
      wait_done(v.d, base, 20000);
      chk("lines_delivered", dlv[v.d], v.exp_lines);
      if (v.exp_lines > 0) chk("last_index", last_idx[v.d], v.exp_last);
      if (v.rdy == 2) chk("held_cycles", hcnt[v.d], 5);
      tick();
      chk("idle_busy", busy[v.d], 0);
      chk("single_done", done[v.d], 0);
   endtask

   initial begin
      int   base;
      int   n;
      vec_t v;

      reset = 1'b1; start = '0; wreq = '0; ready = '1;
      first_line = '0; num_lines = '0; salt = '0;
      for (int d = 0; d < 2; d++) begin
         prep(d, 0, 0);
         exp_slice[d] = 0; done_cnt[d] = 0; last_idx[d] = '0;
      end
      clear_prev();

      tbl[0] = '{0, 8'd3,   9'd1,   0, 0, 8'h00,         1,   8'd3};
      tbl[1] = '{0, 8'd3,   9'd1,   2, 0, 8'h00,         1,   8'd3};
      tbl[2] = '{0, 8'd255, 9'd2,   0, 2, 8'hA5,         2,   8'd0};
      tbl[3] = '{1, 8'd3,   9'd1,   0, 0, 8'h00,         1,   8'd3};
      tbl[4] = '{1, 8'h40,  9'd4,   0, 0, 8'h3C,         4,   8'h43};
      tbl[5] = '{1, 8'd254, 9'd3,   1, 1, 8'($urandom),  3,   8'd0};
      tbl[6] = '{0, 8'd100, 9'd5,   1, 1, 8'($urandom),  5,   8'd104};
      tbl[7] = '{1, 8'd0,   9'd256, 1, 1, 8'($urandom),  256, 8'd255};
      tbl[8] = '{0, 8'hF0,  9'd0,   1, 1, 8'h00,         0,   8'd0};

      repeat (3) tick();
      for (int d = 0; d < 2; d++) check_zero(d, "reset");
      reset = 1'b0;
      tick();

      for (int i = 0; i < 9; i++) run_vec(tbl[i]);

      // Empty readout: done the cycle after start, no bus traffic.
      prep(0, 0, 0);
      base = done_cnt[0];
      start_readout(0, 8'd9, 9'd0);
      chk("zero_done", done[0], 1);
      chk("zero_busy", busy[0], 1);
      tick();
      chk("zero_done_end", done[0], 0);
      chk("zero_idle", busy[0], 0);
      repeat (3) begin tick(); chk("zero_quiet", m_read[0] | m_write[0], 0); end
      chk("zero_done_count", done_cnt[0], base + 1);

      // A start while busy must not queue or restart anything.
      prep(0, 0, 0);
      base = done_cnt[0];
      start_readout(0, 8'd7, 9'd1);
      repeat (3) tick();
      chk("busy_mid", busy[0], 1);
      first_line = 8'd50; num_lines = 9'd3; start[0] = 1'b1;
      tick();
      start[0] = 1'b0;
      wait_done(0, base, 200);
      chk("ignored_lines", dlv[0], 1);
      chk("ignored_last", last_idx[0], 7);
      repeat (20) tick();
      chk("ignored_done_count", done_cnt[0], base + 1);
      chk("ignored_idle", busy[0], 0);

      // Reset during RD of the third line with read latency 3; late data must be dropped.
      prep(1, 0, 0);
      salt = 8'h77;
      start_readout(1, 8'h80, 9'd4);
      n = 0;
      while (!(dlv[1] == 2 && m_read[1] && m_address[1] == 5'd3) && n < 500) begin tick(); n++; end
      if (n >= 500) flag("rd_line2_timeout", n);
      reset = 1'b1;
      clear_prev();
      tick();
      check_zero(1, "midrst");
      reset = 1'b0;
      expq[1].delete();
      repeat (5) begin
         tick();
         chk("post_rst_ldata", line_data[1], 0);
         chk("post_rst_busy", busy[1], 0);
      end
      chk("post_rst_lines", dlv[1], 2);
      v = '{1, 8'h20, 9'd2, 1, 1, 8'h5E, 2, 8'h21};
      run_vec(v);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule

// File: doc/mult_result_reader.md
MULT_RESULT_READER -- requirements
Module: mult_result_reader

Interface
REQ-001 Parameter: LINE_AW, default 8, line address width of the result RAM.
REQ-002 Parameter: WORDS, default 8, number of 32-bit slices per line (line width 32*WORDS = 256).
REQ-003 Parameter: LINE_SEL_ADDR, default 16, slave word address of the line-select register.
REQ-004 Parameter: READ_LATENCY, default 1, cycles from accepted read to valid m_readdata (range 1..4).
REQ-005 Port: avalon_clock, input, 1, the block's only clock; all logic is rising-edge.
REQ-006 Port: reset, input, 1, synchronous, active-high reset.
REQ-007 Port: start, input, 1, single-cycle request to begin a readout.
REQ-008 Port: first_line, input, LINE_AW, first result line to read.
REQ-009 Port: num_lines, input, LINE_AW+1, number of lines to read (0..256).
REQ-010 Port: busy / done, output, 1 each, readout in progress / one-cycle completion pulse.
REQ-011 Port: m_read, m_write, output, 1 each, Avalon-MM master commands.
REQ-012 Port: m_address, output, 5, slave word address.
REQ-013 Port: m_writedata, output, 32, write data.
REQ-014 Port: m_readdata, input, 32, read data.
REQ-015 Port: m_waitrequest, input, 1, slave stall.
REQ-016 Port: line_valid, output, 1; line_ready, input, 1; valid/ready handshake for the output stream.
REQ-017 Port: line_data, output, 32*WORDS, assembled line; line_index, output, LINE_AW, source line number.

Function
REQ-018 FSM states: IDLE, SEL, RD, DRAIN, OUT, FIN; reset enters IDLE.
REQ-019 IDLE: start with num_lines=0 -> FIN (done pulse next cycle, no bus activity); start with num_lines>0 -> latch first_line/num_lines, go SEL; start while not IDLE is ignored.
REQ-020 SEL: m_write=1, m_address=LINE_SEL_ADDR, m_writedata=zero-extended current line; held stable until a cycle with m_waitrequest=0, then go RD.
REQ-021 RD: m_read=1 with m_address = slice 0..WORDS-1 in ascending order; address advances only on cycles with m_waitrequest=0; after slice WORDS-1 is accepted, go DRAIN.
REQ-022 Reads are pipelined: one read issued per unstalled cycle; m_readdata for the read accepted in cycle t is captured in cycle t+READ_LATENCY into bits [32k+31:32k] of line_data, where k is that read's slice number.
REQ-023 DRAIN: wait until all WORDS slices are captured, then go OUT with line_valid=1.
REQ-024 OUT: line_data and line_index are held stable while line_valid=1 and line_ready=0; on line_valid & line_ready, decrement the remaining count; if zero go FIN, else increment the line modulo 2^LINE_AW and go SEL.
REQ-025 Line address wraps: first_line=255, num_lines=2 reads lines 255 then 0.
REQ-026 FIN: done=1 for exactly one cycle, then IDLE.
REQ-027 m_read and m_write are never high in the same cycle; both are 0 outside SEL/RD.
REQ-028 busy=1 in every state other than IDLE.

Reset
REQ-029 Reset (any state, including mid-burst): next cycle in IDLE; busy, done, m_read, m_write, line_valid are 0; m_address, m_writedata, line_data, line_index are 0.
REQ-030 A partial line at reset is discarded; read data returning after reset is ignored.

Verification
REQ-031 first_line=3, num_lines=1, no stalls, READ_LATENCY=1, slave slice k returns 0x0300_0000+k -> one write of 3 to address 16, reads at 0..7, line_data slice k = 0x0300_0000+k, line_index=3, done pulse.
REQ-032 Same readout, with m_waitrequest high for 3 cycles on the write and on slice 4 -> command/address held stable while stalled, identical data, no duplicated or skipped slice.
REQ-033 first_line=255, num_lines=2, line_ready held low 5 cycles on the first line -> line_data stable for 5 cycles, lines 255 then 0 delivered, no bus activity while OUT.
REQ-034 num_lines=0 -> done pulse one cycle after start, m_read/m_write never asserted; start pulsed while busy -> ignored.
REQ-035 READ_LATENCY=3, num_lines=4 -> all 32 slices land in the correct positions; reset asserted during RD of line 2 -> all outputs 0 next cycle, late readdata not captured, new start works normally.
